hex_entry_display: RTL and testbench
====================================

# hex_entry_display

Parametrised hex-digit entry register and multiplexed seven-segment driver for the board top level. It replaces the fixed 32-bit shift register, 8-digit segment controller and divided display clock with one block on the system clock. Pulses from the existing debouncers enter, delete or clear nibbles from the switches. The block scans the entered value onto an N-digit common-anode display using a clock-enable prescaler instead of a derived clock.

## Interface
- DIGITS, 8, number of display digits and stored nibbles (1..16)
- SCAN_DIV, 1000, clk cycles per digit slot (>=2)
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous reset, active-high
- nibble  in  4  value to enter (switches)
- enter_en  in  1  one-cycle pulse: push nibble
- del_en  in  1  one-cycle pulse: remove last nibble
- clr_en  in  1  one-cycle pulse: clear all
- value  out  4*DIGITS  entered number, last-entered nibble in bits [3:0]
- count  out  $clog2(DIGITS+1)  nibbles currently entered
- overflow  out  1  one-cycle pulse: enter rejected because full
- anodes  out  DIGITS  digit selects, active-low
- cathodes  out  8  {dp,g,f,e,d,c,b,a}, active-low

## Operation
- Reset values: value 0, count 0, overflow 0, anodes all 1, cathodes 8'hFF, digit index 0, prescaler 0.
- Priority when pulses coincide: clr_en > del_en > enter_en. Only one action per cycle. Lower-priority pulses in that cycle are dropped.
- clr_en: value <= 0, count <= 0.
- del_en, count>0: value <= value >> 4, count <= count-1. If count==0: no-op.
- enter_en, count<DIGITS: value <= {value[4*DIGITS-5:0], nibble}, count <= count+1. For DIGITS==1: value <= nibble.
- enter_en, count==DIGITS: value and count unchanged, overflow pulses for one cycle.
- count saturates in both directions and never leaves 0..DIGITS.
- Scan prescaler counts 0..SCAN_DIV-1 and wraps. The tick is prescaler==SCAN_DIV-1.
- On each tick, the digit index advances and wraps from DIGITS-1 to 0. The first tick after reset selects digit 0.
- On each tick, anodes and cathodes are registered together for the new index:
  - anodes has a single 0 at the index position.
  - cathodes = {1'b1, seg(value[4*idx+3:4*idx])}. The decimal point is always off.
- seg mapping (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Digit 0 is the rightmost digit and shows value[3:0].

## Timing
- value, count and overflow update on the clk edge following the pulse cycle. Latency is 1.
- The display reflects a value change at the next digit slot. Worst case is DIGITS*SCAN_DIV cycles for the changed digit to appear.
- The full refresh period is DIGITS*SCAN_DIV cycles. At 100 MHz with the defaults this is 80 µs.
- Between reset release and the first tick (SCAN_DIV cycles), all digits are dark.
- A reset asserted mid-scan immediately blanks the display and returns every register to its reset value. There is no clock dependency.
- Inputs are synchronous pulses from the debouncers. The block does no edge detection: a level held for k cycles acts k times.

## Configuration
- HEX_ENTRY_BLANK_LZ_EN defined:
  - Leading-zero blanking is on. Digits at index >= count drive cathodes 8'hFF, while their anode is still scanned.
  - Exception: when count==0, digit 0 shows "0".
- Not defined: all DIGITS digits always show their nibble, including leading zeros.
- The macro does not affect value, count or overflow.

## Structure
- Package seg_pkg holds:
  - the SEG_BLANK = 8'hFF constant;
  - the 16-entry hex-to-segment constant table;
  - the cathode bit-order definition.
- Sub-module hex7seg_decoder: combinational nibble-to-cathode decode using seg_pkg. The registered output stays in the parent.
- Parent contains the entry register and count, the prescaler, the digit index, and the registered anode/cathode outputs.

## Test plan
Use DIGITS=4 and SCAN_DIV=4 unless noted.
- Reset: assert rst mid-scan -> anodes=4'hF, cathodes=8'hFF, value=0, count=0 asynchronously. After release, the first anode change (anodes=4'hE) occurs exactly 4 cycles later.
- Entry: enter 1,2,3,4 -> value=16'h1234, count=4. A fifth enter with 5 -> value unchanged and overflow high for exactly one cycle.
- Delete/clear: from 16'h1234, del -> 16'h0123, count=3. Four further dels -> 0, count=0, with no underflow. Enter A then clr -> 0.
- Priority: del_en, enter_en and clr_en in the same cycle with value 16'h0012 -> value 0. del_en with enter_en -> delete only.
- Scan: value 16'hBEEF over 16 cycles -> anodes cycles E,D,B,7 with cathodes showing F,E,E,b, each held 4 cycles. Anode and cathode change on the same edge.
- Blanking: with HEX_ENTRY_BLANK_LZ_EN and value 16'h0007, count=1 -> digits 1..3 show 8'hFF and digit 0 shows 7. After clr, digit 0 shows "0". Without the macro, digits 1..3 show "0".

Source files
------------

// File: rtl/hex_entry_display_pkg.sv
// seg_pkg: shared seven-segment definitions for the hex entry display.
// Cathode byte order is {dp,g,f,e,d,c,b,a}, all segments active-low.
package seg_pkg;

    // Every segment and the decimal point off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bit order of one cathode byte.
    typedef struct packed {
        logic dp;
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } cathode_t;

    // Active-low {g,f,e,d,c,b,a} pattern per hex digit, indexed by the nibble.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Full cathode byte for a nibble; the decimal point is never lit.
    function automatic cathode_t seg_encode(input logic [3:0] nib);
        cathode_t c;
        c = {1'b1, SEG_TABLE[nib]};
        return c;
    endfunction

endpackage

// File: rtl/hex_entry_display_if.sv
// Bundle of the entry pulses and display/status outputs of hex_entry_display.
//
// Handshake: there is no ready/backpressure. enter_en, del_en and clr_en are
// synchronous one-cycle pulses sampled on every rising clk edge; a level held
// for k cycles is acted on k times. When several are high in one cycle only
// the highest priority one (clr > del > enter) takes effect, the rest are
// dropped. value/count/overflow are valid one cycle after the pulse.
interface hex_entry_display_if #(
    parameter int DIGITS = 8
);
    localparam int CW = $clog2(DIGITS + 1);

    logic [3:0]          nibble;
    logic                enter_en;
    logic                del_en;
    logic                clr_en;
    logic [4*DIGITS-1:0] value;
    logic [CW-1:0]       count;
    logic                overflow;
    logic [DIGITS-1:0]   anodes;
    logic [7:0]          cathodes;

    // Board-side driver of the pulses, observer of the display.
    modport master (
        output nibble,
        output enter_en,
        output del_en,
        output clr_en,
        input  value,
        input  count,
        input  overflow,
        input  anodes,
        input  cathodes
    );

    // The entry/display block itself.
    modport slave (
        input  nibble,
        input  enter_en,
        input  del_en,
        input  clr_en,
        output value,
        output count,
        output overflow,
        output anodes,
        output cathodes
    );

endinterface

// File: rtl/hex_entry_display_hex7seg.sv
// hex7seg_decoder: combinational nibble-to-cathode decode with a blank override.
module hex7seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [7:0] cathodes_o
);

    // Blanked digits go fully dark; otherwise look up the hex glyph.
    always_comb begin
        cathodes_o = SEG_BLANK;
        if (!blank_i) begin
            cathodes_o = seg_encode(nibble_i);
        end
    end

endmodule

// File: rtl/hex_entry_display.sv
// hex_entry_display: hex nibble entry register with a multiplexed
// common-anode seven-segment scanner, all on the system clock.
// Optional macro HEX_ENTRY_BLANK_LZ_EN: blank digits at index >= count
// (digit 0 still shows "0" when nothing is entered).
module hex_entry_display
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    hex_entry_display_if.slave  bus
);

    localparam int VW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0]     COUNT_MAX = CW'(DIGITS);
    localparam logic [CW-1:0]     COUNT_ONE = CW'(1);
    localparam logic [PW-1:0]     PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]     PRESC_ONE = PW'(1);
    localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [IW-1:0]     IDX_ONE   = IW'(1);
    localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);

    // Entry state
    logic [VW-1:0] value_q, value_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    // Scan state
    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              tick;
    logic [DIGITS-1:0] anodes_q, anodes_d;
    logic [7:0]        cathodes_q, cathodes_d;
    logic [3:0]        cur_nibble;
    logic              blank;

    // Next entry state: one action per cycle, clear beats delete beats enter.
    always_comb begin
        value_d    = value_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        if (bus.clr_en) begin
            value_d = '0;
            count_d = '0;
        end else if (bus.del_en) begin
            if (count_q != '0) begin
                value_d = value_q >> 4;
                count_d = count_q - COUNT_ONE;
            end
        end else if (bus.enter_en) begin
            if (count_q < COUNT_MAX) begin
                // For a single digit the shift empties the register entirely.
                value_d = (value_q << 4) | VW'(bus.nibble);
                count_d = count_q + COUNT_ONE;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Entry register, count and overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign tick = (presc_q == PRESC_MAX);

    // Prescaler wrap and digit index advance. idx_q names the digit loaded on
    // the coming tick, so starting at 0 makes the first tick show digit 0.
    always_comb begin
        presc_d = presc_q + PRESC_ONE;
        idx_d   = idx_q;
        if (tick) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? '0 : (idx_q + IDX_ONE);
        end
    end

    assign cur_nibble = value_q[{idx_q, 2'b00} +: 4];

`ifdef HEX_ENTRY_BLANK_LZ_EN
    // Leading-zero blanking, keeping a lone "0" on digit 0 when empty.
    always_comb begin
        blank = 1'b0;
        if (32'(idx_q) >= 32'(count_q)) begin
            blank = 1'b1;
        end
        if ((count_q == '0) && (idx_q == '0)) begin
            blank = 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

    hex7seg_decoder u_dec (
        .nibble_i   (cur_nibble),
        .blank_i    (blank),
        .cathodes_o (cathodes_d)
    );

    assign anodes_d = ~(AN_ONE << idx_q);

    // Scan counters and the display outputs, anode and cathode loaded together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            anodes_q   <= '1;
            cathodes_q <= SEG_BLANK;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (tick) begin
                anodes_q   <= anodes_d;
                cathodes_q <= cathodes_d;
            end
        end
    end

    assign bus.value    = value_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.anodes   = anodes_q;
    assign bus.cathodes = cathodes_q;

endmodule

// File: tb/tb_hex_entry_display.sv
// Directed bench for hex_entry_display with DIGITS=4, SCAN_DIV=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hex_entry_display;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    // Expected cathode bytes
    localparam logic [7:0] C_0 = 8'hC0;
    localparam logic [7:0] C_7 = 8'hF8;
    localparam logic [7:0] C_B = 8'h83;
    localparam logic [7:0] C_E = 8'h86;
    localparam logic [7:0] C_F = 8'h8E;
`ifdef HEX_ENTRY_BLANK_LZ_EN
    localparam logic [7:0] C_LZ = 8'hFF;
`else
    localparam logic [7:0] C_LZ = 8'hC0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hex_entry_display_if #(.DIGITS(DIGITS)) bus ();

    hex_entry_display #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of pulses, returning on the next falling edge.
    task automatic pulse(input logic e, input logic d, input logic c, input logic [3:0] n);
        bus.enter_en = e;
        bus.del_en   = d;
        bus.clr_en   = c;
        bus.nibble   = n;
        @(negedge clk);
        bus.enter_en = 1'b0;
        bus.del_en   = 1'b0;
        bus.clr_en   = 1'b0;
    endtask

    task automatic enter(input logic [3:0] n);
        pulse(1'b1, 1'b0, 1'b0, n);
    endtask

    // Wait (bounded) for a fresh switch to digit 0; returns just after that tick.
    task automatic sync_digit0(input string tag);
        logic [3:0] prev;
        logic       ok;
        prev = bus.anodes;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.anodes == 4'hE && prev != 4'hE) begin
                ok = 1'b1;
                break;
            end
            prev = bus.anodes;
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        logic [3:0] exp_an [4];
        logic [7:0] exp_cat [4];

        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.nibble   = 4'h0;
        bus.enter_en = 1'b0;
        bus.del_en   = 1'b0;
        bus.clr_en   = 1'b0;
        exp_an[0] = 4'hE;
        exp_an[1] = 4'hD;
        exp_an[2] = 4'hB;
        exp_an[3] = 4'h7;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_value", 64'(bus.value), 64'h0);
        check("rst_count", 64'(bus.count), 64'h0);
        check("rst_overflow", 64'(bus.overflow), 64'h0);
        check("rst_anodes", 64'(bus.anodes), 64'hF);
        check("rst_cathodes", 64'(bus.cathodes), 64'hFF);

        // First digit appears exactly SCAN_DIV cycles after release
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("dark_before_tick", 64'(bus.anodes), 64'hF);
        end
        @(negedge clk);
        check("first_tick_anodes", 64'(bus.anodes), 64'hE);
        check("first_tick_cathodes", 64'(bus.cathodes), 64'(C_0));

        // Entry and overflow
        enter(4'h1);
        check("enter1_value", 64'(bus.value), 64'h0001);
        check("enter1_count", 64'(bus.count), 64'd1);
        enter(4'h2);
        enter(4'h3);
        enter(4'h4);
        check("enter4_value", 64'(bus.value), 64'h1234);
        check("enter4_count", 64'(bus.count), 64'd4);
        check("no_overflow_yet", 64'(bus.overflow), 64'h0);
        enter(4'h5);
        check("full_value", 64'(bus.value), 64'h1234);
        check("full_count", 64'(bus.count), 64'd4);
        check("overflow_pulse", 64'(bus.overflow), 64'h1);
        @(negedge clk);
        check("overflow_one_cycle", 64'(bus.overflow), 64'h0);

        // Delete down past empty
        pulse(1'b0, 1'b1, 1'b0, 4'h0);
        check("del1_value", 64'(bus.value), 64'h0123);
        check("del1_count", 64'(bus.count), 64'd3);
        pulse(1'b0, 1'b1, 1'b0, 4'h0);
        pulse(1'b0, 1'b1, 1'b0, 4'h0);
        pulse(1'b0, 1'b1, 1'b0, 4'h0);
        check("del4_value", 64'(bus.value), 64'h0);
        check("del4_count", 64'(bus.count), 64'd0);
        pulse(1'b0, 1'b1, 1'b0, 4'h0);
        check("del_empty_value", 64'(bus.value), 64'h0);
        check("del_empty_count", 64'(bus.count), 64'd0);

        // Clear
        enter(4'hA);
        check("enterA_value", 64'(bus.value), 64'h000A);
        pulse(1'b0, 1'b0, 1'b1, 4'h0);
        check("clr_value", 64'(bus.value), 64'h0);
        check("clr_count", 64'(bus.count), 64'd0);

        // Priority
        enter(4'h1);
        enter(4'h2);
        check("pri_setup", 64'(bus.value), 64'h0012);
        pulse(1'b1, 1'b1, 1'b1, 4'h7);
        check("pri_all_value", 64'(bus.value), 64'h0);
        check("pri_all_count", 64'(bus.count), 64'd0);
        enter(4'h1);
        enter(4'h2);
        pulse(1'b1, 1'b1, 1'b0, 4'h9);
        check("pri_del_enter_value", 64'(bus.value), 64'h0001);
        check("pri_del_enter_count", 64'(bus.count), 64'd1);

        // Scan of BEEF: each slot held SCAN_DIV cycles
        pulse(1'b0, 1'b0, 1'b1, 4'h0);
        enter(4'hB);
        enter(4'hE);
        enter(4'hE);
        enter(4'hF);
        check("beef_value", 64'(bus.value), 64'hBEEF);
        exp_cat[0] = C_F;
        exp_cat[1] = C_E;
        exp_cat[2] = C_E;
        exp_cat[3] = C_B;
        sync_digit0("beef_sync");
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("beef_an_s%0d_c%0d", s, c), 64'(bus.anodes), 64'(exp_an[s]));
                check($sformatf("beef_cat_s%0d_c%0d", s, c), 64'(bus.cathodes), 64'(exp_cat[s]));
                @(negedge clk);
            end
        end

        // Asynchronous reset mid-scan, away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_anodes", 64'(bus.anodes), 64'hF);
        check("async_rst_cathodes", 64'(bus.cathodes), 64'hFF);
        check("async_rst_value", 64'(bus.value), 64'h0);
        check("async_rst_count", 64'(bus.count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Leading digits with one entered nibble
        enter(4'h7);
        check("seven_value", 64'(bus.value), 64'h0007);
        check("seven_count", 64'(bus.count), 64'd1);
        exp_cat[0] = C_7;
        exp_cat[1] = C_LZ;
        exp_cat[2] = C_LZ;
        exp_cat[3] = C_LZ;
        sync_digit0("seven_sync");
        for (int s = 0; s < 4; s++) begin
            check($sformatf("seven_an_s%0d", s), 64'(bus.anodes), 64'(exp_an[s]));
            check($sformatf("seven_cat_s%0d", s), 64'(bus.cathodes), 64'(exp_cat[s]));
            repeat (4) @(negedge clk);
        end

        // Empty display: digit 0 still shows "0"
        pulse(1'b0, 1'b0, 1'b1, 4'h0);
        exp_cat[0] = C_0;
        sync_digit0("empty_sync");
        for (int s = 0; s < 4; s++) begin
            check($sformatf("empty_an_s%0d", s), 64'(bus.anodes), 64'(exp_an[s]));
            check($sformatf("empty_cat_s%0d", s), 64'(bus.cathodes), 64'(exp_cat[s]));
            repeat (4) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
